// File: rtl/ps2_scancode_ascii_fifo_if.sv
// Keyboard character path bundle: scan-code bytes in from the PS/2 receiver,
// ASCII characters out to the consumer over a valid/ready handshake.
interface ps2_scancode_ascii_fifo_if;
  logic       PS2_Done_Sig;
  logic [7:0] PS2_Data;
  logic [7:0] Key_Data;
  logic       Key_Valid;
  logic       Key_Ready;

  modport master (
    output PS2_Done_Sig,
    output PS2_Data,
    output Key_Ready,
    input  Key_Data,
    input  Key_Valid
  );

  modport slave (
    input  PS2_Done_Sig,
    input  PS2_Data,
    input  Key_Ready,
    output Key_Data,
    output Key_Valid
  );
endinterface

// File: rtl/ps2_scancode_ascii_fifo.sv
// PS/2 Set-2 scan-code to ASCII decoder with a show-ahead character FIFO.
// Tracks break (F0) and extended (E0) prefixes plus both Shift keys.
module ps2_scancode_ascii_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CASE_MODE  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  ps2_scancode_ascii_fifo_if.slave      kb,
  output logic                          Shift_State,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic [3:0]                    LED
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t         state, state_nxt;
  logic           shift_l, shift_r, shift_l_nxt, shift_r_nxt;
  logic           push;
  logic           map_hit, is_letter, upper;
  logic [7:0]     map_char, push_char;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           pop, full, write_en;

  assign Shift_State = shift_l | shift_r;
  assign upper       = (CASE_MODE == 0) || Shift_State;
  assign push_char   = (is_letter && !upper) ? (map_char | 8'h20) : map_char;

  // Decoder state, shift flags and LED only move on a received byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      LED     <= 4'h0;
    end else if (kb.PS2_Done_Sig) begin
      state   <= state_nxt;
      shift_l <= shift_l_nxt;
      shift_r <= shift_r_nxt;
      LED     <= kb.PS2_Data[3:0];
    end
  end

  // Scan-code lookup; letters come out upper case and are folded down later.
  always_comb begin
    map_hit   = 1'b1;
    is_letter = 1'b0;
    map_char  = 8'h00;
    case (kb.PS2_Data)
      8'h45: map_char = 8'h30;
      8'h16: map_char = 8'h31;
      8'h1E: map_char = 8'h32;
      8'h26: map_char = 8'h33;
      8'h25: map_char = 8'h34;
      8'h2E: map_char = 8'h35;
      8'h36: map_char = 8'h36;
      8'h3D: map_char = 8'h37;
      8'h3E: map_char = 8'h38;
      8'h46: map_char = 8'h39;
      8'h1C: begin map_char = 8'h41; is_letter = 1'b1; end
      8'h32: begin map_char = 8'h42; is_letter = 1'b1; end
      8'h21: begin map_char = 8'h43; is_letter = 1'b1; end
      8'h23: begin map_char = 8'h44; is_letter = 1'b1; end
      8'h24: begin map_char = 8'h45; is_letter = 1'b1; end
      8'h2B: begin map_char = 8'h46; is_letter = 1'b1; end
      8'h34: begin map_char = 8'h47; is_letter = 1'b1; end
      8'h33: begin map_char = 8'h48; is_letter = 1'b1; end
      8'h43: begin map_char = 8'h49; is_letter = 1'b1; end
      8'h3B: begin map_char = 8'h4A; is_letter = 1'b1; end
      8'h42: begin map_char = 8'h4B; is_letter = 1'b1; end
      8'h4B: begin map_char = 8'h4C; is_letter = 1'b1; end
      8'h3A: begin map_char = 8'h4D; is_letter = 1'b1; end
      8'h31: begin map_char = 8'h4E; is_letter = 1'b1; end
      8'h44: begin map_char = 8'h4F; is_letter = 1'b1; end
      8'h4D: begin map_char = 8'h50; is_letter = 1'b1; end
      8'h15: begin map_char = 8'h51; is_letter = 1'b1; end
      8'h2D: begin map_char = 8'h52; is_letter = 1'b1; end
      8'h1B: begin map_char = 8'h53; is_letter = 1'b1; end
      8'h2C: begin map_char = 8'h54; is_letter = 1'b1; end
      8'h3C: begin map_char = 8'h55; is_letter = 1'b1; end
      8'h2A: begin map_char = 8'h56; is_letter = 1'b1; end
      8'h1D: begin map_char = 8'h57; is_letter = 1'b1; end
      8'h22: begin map_char = 8'h58; is_letter = 1'b1; end
      8'h35: begin map_char = 8'h59; is_letter = 1'b1; end
      8'h1A: begin map_char = 8'h5A; is_letter = 1'b1; end
      8'h29: map_char = 8'h20;
      8'h5A: map_char = 8'h0D;
      8'h66: map_char = 8'h08;
      default: map_hit = 1'b0;
    endcase
  end

  // Prefix tracking; only plain make codes in IDLE produce a character.
  always_comb begin
    state_nxt   = state;
    shift_l_nxt = shift_l;
    shift_r_nxt = shift_r;
    push        = 1'b0;
    if (kb.PS2_Done_Sig) begin
      case (state)
        IDLE: begin
          if (kb.PS2_Data == 8'hF0)      state_nxt   = BREAK;
          else if (kb.PS2_Data == 8'hE0) state_nxt   = EXT;
          else if (kb.PS2_Data == 8'h12) shift_l_nxt = 1'b1;
          else if (kb.PS2_Data == 8'h59) shift_r_nxt = 1'b1;
          else if (map_hit)              push        = 1'b1;
        end
        BREAK: begin
          if (kb.PS2_Data == 8'h12) shift_l_nxt = 1'b0;
          if (kb.PS2_Data == 8'h59) shift_r_nxt = 1'b0;
          state_nxt = IDLE;
        end
        EXT:       state_nxt = (kb.PS2_Data == 8'hF0) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign pop            = kb.Key_Valid & kb.Key_Ready;
  assign full           = (count == DEPTH_C);
  assign write_en       = push && (!full || pop);
  assign kb.Key_Valid   = (count != '0);
  assign kb.Key_Data    = kb.Key_Valid ? mem[rd_ptr] : 8'h00;
  assign Fifo_Count     = count;

  // Character storage; contents are only visible through the valid gate.
  always_ff @(posedge CLK) begin
    if (write_en) mem[wr_ptr] <= push_char;
  end

  // Pointer and occupancy bookkeeping; a blocked push latches Overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) Overflow <= 1'b1;
      case ({write_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_ascii_fifo.sv
// Bench for the scan-code FIFO: two instances (Shift-aware and legacy upper
// case) share one stimulus stream and are compared to a queue-based model.
module tb_ps2_scancode_ascii_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;

  logic       shift_1, shift_0, ovf_1, ovf_0;
  logic [3:0] led_1, led_0;
  logic [$clog2(DEPTH):0] cnt_1, cnt_0;

  int checks = 0;
  int errors = 0;

  ps2_scancode_ascii_fifo_if kb1 ();
  ps2_scancode_ascii_fifo_if kb0 ();

  assign kb1.PS2_Done_Sig = done;
  assign kb1.PS2_Data     = data;
  assign kb1.Key_Ready    = ready;
  assign kb0.PS2_Done_Sig = done;
  assign kb0.PS2_Data     = data;
  assign kb0.Key_Ready    = ready;

  ps2_scancode_ascii_fifo #(.FIFO_DEPTH(DEPTH), .CASE_MODE(1)) dut_shift (
    .CLK(clk), .RST(rst), .kb(kb1), .Shift_State(shift_1),
    .Overflow(ovf_1), .Fifo_Count(cnt_1), .LED(led_1)
  );

  ps2_scancode_ascii_fifo #(.FIFO_DEPTH(DEPTH), .CASE_MODE(0)) dut_upper (
    .CLK(clk), .RST(rst), .kb(kb0), .Shift_State(shift_0),
    .Overflow(ovf_0), .Fifo_Count(cnt_0), .LED(led_0)
  );

  always #5 clk = ~clk;

  // Reference keyboard tables and model state
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};

  bit         m_e0, m_f0, m_sl, m_sr, m_ovf;
  logic [3:0] m_led;
  logic [7:0] q1 [$];
  logic [7:0] q0 [$];

  function automatic int mapCode(logic [7:0] b, bit up);
    for (int i = 0; i < 10; i++) if (b == digit_codes[i]) return 'h30 + i;
    for (int i = 0; i < 26; i++) if (b == letter_codes[i]) return (up ? 'h41 : 'h61) + i;
    if (b == 8'h29) return 'h20;
    if (b == 8'h5A) return 'h0D;
    if (b == 8'h66) return 'h08;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock of stimulus: predict the post-edge state, then compare.
  task automatic applyStimulus(input bit rst_v, input bit done_v, input logic [7:0] data_v, input bit ready_v);
    bit pop, push, full;
    int c1, c0;
    @(negedge clk);
    rst = rst_v; done = done_v; data = data_v; ready = ready_v;
    push = 0; c1 = -1; c0 = -1;
    if (rst_v) begin
      m_e0 = 0; m_f0 = 0; m_sl = 0; m_sr = 0; m_ovf = 0; m_led = 4'h0;
      q1.delete(); q0.delete();
    end else begin
      pop = (q1.size() > 0) && ready_v;
      if (done_v) begin
        m_led = data_v[3:0];
        if (m_e0) begin
          if (!m_f0 && data_v == 8'hF0) m_f0 = 1;
          else begin m_e0 = 0; m_f0 = 0; end
        end else if (m_f0) begin
          if (data_v == 8'h12) m_sl = 0;
          if (data_v == 8'h59) m_sr = 0;
          m_f0 = 0;
        end else if (data_v == 8'hF0) m_f0 = 1;
        else if (data_v == 8'hE0) m_e0 = 1;
        else if (data_v == 8'h12) m_sl = 1;
        else if (data_v == 8'h59) m_sr = 1;
        else begin
          c1 = mapCode(data_v, m_sl | m_sr);
          c0 = mapCode(data_v, 1'b1);
          push = (c1 >= 0);
        end
      end
      full = (q1.size() == DEPTH);
      if (pop) begin void'(q1.pop_front()); void'(q0.pop_front()); end
      if (push) begin
        if (!full || pop) begin q1.push_back(8'(c1)); q0.push_back(8'(c0)); end
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("valid1", kb1.Key_Valid, q1.size() > 0);
    checkOutput("data1",  kb1.Key_Data,  q1.size() > 0 ? q1[0] : 8'h00);
    checkOutput("count1", cnt_1, q1.size());
    checkOutput("ovf1",   ovf_1, m_ovf);
    checkOutput("shift1", shift_1, m_sl | m_sr);
    checkOutput("led1",   led_1, m_led);
    checkOutput("valid0", kb0.Key_Valid, q0.size() > 0);
    checkOutput("data0",  kb0.Key_Data,  q0.size() > 0 ? q0[0] : 8'h00);
    checkOutput("count0", cnt_0, q0.size());
    checkOutput("ovf0",   ovf_0, m_ovf);
    checkOutput("shift0", shift_0, m_sl | m_sr);
    checkOutput("led0",   led_0, m_led);
  endtask

  task automatic key(input logic [7:0] b, input bit ready_v);
    applyStimulus(1'b0, 1'b1, b, ready_v);
  endtask

  task automatic idle(input int n, input bit ready_v);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom), ready_v);
  endtask

  // Directed scenarios followed by a randomized soak
  initial begin
    logic [7:0] b;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    key(8'h1C, 1'b1); key(8'hF0, 1'b1); key(8'h1C, 1'b1); idle(3, 1'b1);

    key(8'h12, 1'b0); key(8'h1C, 1'b0); key(8'hF0, 1'b0); key(8'h12, 1'b0);
    key(8'h1C, 1'b0); idle(4, 1'b1);

    key(8'hE0, 1'b0); key(8'h5A, 1'b0); key(8'hE0, 1'b0); key(8'hF0, 1'b0);
    key(8'h5A, 1'b0); key(8'h5A, 1'b0); idle(3, 1'b1);

    for (int i = 0; i < DEPTH + 1; i++) key(8'h16, 1'b0);
    key(8'h16, 1'b1);
    idle(DEPTH + 2, 1'b1);

    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      key(digit_codes[$urandom_range(0, 9)], 1'(i % 3 == 0));
      if (i % 4 == 3) idle(1, 1'b1);
    end
    idle(DEPTH + 2, 1'b1);

    for (int i = 0; i < 3; i++) key(8'h16, 1'b0);
    key(8'hE0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    key(8'h16, 1'b0);
    idle(2, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        3: b = 8'($urandom);
        4, 5: b = digit_codes[$urandom_range(0, 9)];
        default: b = letter_codes[$urandom_range(0, 25)];
      endcase
      applyStimulus(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 2) != 0),
                    b, 1'($urandom_range(0, 3) == 0));
    end
    idle(DEPTH + 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
